// File: rtl/seq_mul_add.sv
// -----------------------------------------------------------------------------
// seq_mul_add
// Sequential shift-add multiplier-accumulator: P = Multiplicand*Multiplier + Addend.
// This is the inverse of the restoring divider. Feeding it Q, Divisor and R
// rebuilds the Dividend, so it is used for divide-check and round-trip checks.
//
// Handshake: when Ready=1 the block is idle and P is valid. Start is sampled
// only in IDLE; a rising clock edge with Start=1 latches all three operands.
// Ready drops for N+1 cycles, and P updates on the edge that raises Ready again.
// A Start that arrives while Ready=0 is dropped and is not queued.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous, active-high reset
//   Start        - operation request, sampled in IDLE only
//   Multiplicand - operand A (N bits), latched on accepted Start
//   Multiplier   - operand B (N bits), latched on accepted Start
//   Addend       - operand C (N bits), latched on accepted Start
//   P            - result (2N bits), held until the next operation completes
//   Ready        - high when idle and P is valid
//
// Configuration macro:
//   MUL_SIGNED_EN - when defined, the operands are two's complement and the
//                   block uses radix-2 Booth recoding. Cycle count is unchanged.
//                   When undefined, the block does plain unsigned shift-add.
// -----------------------------------------------------------------------------
module seq_mul_add #(
   parameter int N = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           Start,
   input  logic [N-1:0]   Multiplicand,
   input  logic [N-1:0]   Multiplier,
   input  logic [N-1:0]   Addend,
   output logic [2*N-1:0] P,
   output logic           Ready
);

   localparam int CW = $clog2(N+1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [N-1:0]    areg;       // latched multiplicand
   logic [2*N:0]    acc;        // {carry/sign, hi[N], lo[N]}
   logic [CW-1:0]   cnt;
   logic [2*N:0]    acc_step;   // acc after one add-and-shift step

`ifdef MUL_SIGNED_EN
   logic            q_m1;       // Booth history bit q(-1)
   logic [N:0]      hi_x;       // hi treated as an (N+1)-bit signed value
   logic [N:0]      a_x;        // sign-extended multiplicand
   logic [N:0]      hi_new;

   always_comb begin
      hi_x   = acc[2*N:N];
      a_x    = {areg[N-1], areg};
      hi_new = hi_x;
      case ({acc[0], q_m1})
         2'b10:   hi_new = hi_x - a_x;
         2'b01:   hi_new = hi_x + a_x;
         default: hi_new = hi_x;
      endcase
      // Arithmetic right shift of {hi_new, lo}. The sign bit is replicated.
      acc_step = {hi_new[N], hi_new, acc[N-1:1]};
   end
`else
   logic [N:0]      hi_sum;

   always_comb begin
      // The carry bit is always 0 at the start of a step because the previous
      // shift moved it into hi. So {carry,hi} + Areg equals hi + Areg, and the
      // N+1-bit sum cannot overflow.
      hi_sum = acc[2*N:N];
      if (acc[0]) begin
         hi_sum = acc[2*N:N] + {1'b0, areg};
      end
      // Logical right shift. The carry enters the MSB of hi.
      acc_step = {1'b0, hi_sum, acc[N-1:1]};
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         P     <= '0;
         Ready <= 1'b1;
         areg  <= '0;
         acc   <= '0;
         cnt   <= '0;
`ifdef MUL_SIGNED_EN
         q_m1  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               Ready <= 1'b1;
               if (Start) begin
                  areg  <= Multiplicand;
`ifdef MUL_SIGNED_EN
                  // Sign-extend the addend so that a signed C is added.
                  acc   <= {Addend[N-1], Addend, Multiplier};
                  q_m1  <= 1'b0;
`else
                  acc   <= {1'b0, Addend, Multiplier};
`endif
                  cnt   <= '0;
                  Ready <= 1'b0;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_step;
`ifdef MUL_SIGNED_EN
               q_m1 <= acc[0];
`endif
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N-1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // The addend started in hi. After N shifts it sits in the low word.
               P     <= acc[2*N-1:0];
               Ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               Ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul_add.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_add
// Self-checking bench for seq_mul_add (N=6). Each scenario has its own task.
// Expected results are pushed to exp_q when an operation is driven. They are
// popped and compared when the DUT raises Ready.
// -----------------------------------------------------------------------------
module tb_seq_mul_add;

   localparam int N = 6;

   logic           clk;
   logic           rst;
   logic           Start;
   logic [N-1:0]   Multiplicand;
   logic [N-1:0]   Multiplier;
   logic [N-1:0]   Addend;
   logic [2*N-1:0] P;
   logic           Ready;

   logic [2*N-1:0] exp_q[$];
   logic [2*N-1:0] last_p;
   int             tests_run;
   int             fails;
   int             cyc;

   seq_mul_add #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .Start        (Start),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Addend       (Addend),
      .P            (P),
      .Ready        (Ready)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] c);
      int r;
`ifdef MUL_SIGNED_EN
      r = int'($signed(a)) * int'($signed(b)) + int'($signed(c));
`else
      r = int'(a) * int'(b) + int'(c);
`endif
      return r[2*N-1:0];
   endfunction

   // ---------------- driver ----------------
   // Waits for idle, issues one operation, and pushes expv. It then scrambles
   // the inputs and waits for Ready. lat is the number of edges from the accept
   // edge to the edge that raised Ready.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c,
                         input logic [2*N-1:0] expv, output int lat, output bit ok);
      int i;
      int acc_cyc;
      ok = 1'b1;
      @(negedge clk);
      i = 0;
      while (!Ready && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (!Ready) ok = 1'b0;
      Multiplicand = a;
      Multiplier   = b;
      Addend       = c;
      Start        = 1'b1;
      exp_q.push_back(expv);
      @(posedge clk);
      #1;
      acc_cyc      = cyc;
      Start        = 1'b0;
      Multiplicand = N'($urandom_range(0, (1 << N) - 1));
      Multiplier   = N'($urandom_range(0, (1 << N) - 1));
      Addend       = N'($urandom_range(0, (1 << N) - 1));
      i = 0;
      @(negedge clk);
      while (!Ready && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (!Ready) ok = 1'b0;
      lat = cyc - acc_cyc;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (P !== '0) begin
         fails++;
         $display("FAIL reset_p: P=%0d expected 0", P);
      end
      tests_run++;
      if (Ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: Ready=%0b expected 1", Ready);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (P !== '0) begin
         fails++;
         $display("FAIL post_reset_p: P=%0d expected 0", P);
      end
      tests_run++;
      if (Ready !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_ready: Ready=%0b expected 1", Ready);
      end
      last_p = '0;
   endtask

   task automatic test_basic;
      int lat;
      bit ok;
      logic [2*N-1:0] got;
      run_op(6'd5, 6'd7, 6'd3, 12'd38, lat, ok);
      got = exp_q.pop_front();
      tests_run++;
      if (!ok || lat != N + 1 || P !== got) begin
         fails++;
         $display("FAIL basic_5_7_3: P=%0d lat=%0d ok=%0b expected P=%0d lat=%0d", P, lat, ok, got, N + 1);
      end
      last_p = got;
   endtask

`ifdef MUL_SIGNED_EN
   task automatic test_signed;
      int lat;
      bit ok;
      logic [2*N-1:0] got;
      run_op(6'h20, 6'h20, 6'h3F, 12'd1023, lat, ok);
      got = exp_q.pop_front();
      tests_run++;
      if (!ok || lat != N + 1 || P !== got) begin
         fails++;
         $display("FAIL signed_m32_m32_m1: P=%0d lat=%0d expected P=%0d", P, lat, got);
      end
      run_op(6'h3B, 6'd7, 6'd4, 12'hFE1, lat, ok);
      got = exp_q.pop_front();
      tests_run++;
      if (!ok || lat != N + 1 || P !== got) begin
         fails++;
         $display("FAIL signed_m5_7_4: P=%0h lat=%0d expected P=%0h", P, lat, got);
      end
      last_p = got;
   endtask
`else
   task automatic test_max;
      int lat;
      bit ok;
      logic [2*N-1:0] got;
      run_op(6'd63, 6'd63, 6'd63, 12'd4032, lat, ok);
      got = exp_q.pop_front();
      tests_run++;
      if (!ok || lat != N + 1 || P !== got) begin
         fails++;
         $display("FAIL max_63_63_63: P=%0d lat=%0d expected P=%0d", P, lat, got);
      end
      run_op(6'd0, 6'd45, 6'd17, 12'd17, lat, ok);
      got = exp_q.pop_front();
      tests_run++;
      if (!ok || lat != N + 1 || P !== got) begin
         fails++;
         $display("FAIL zero_0_45_17: P=%0d lat=%0d expected P=%0d", P, lat, got);
      end
      last_p = got;
   endtask

   task automatic test_roundtrip;
      int lat;
      bit ok;
      logic [2*N-1:0] got;
      run_op(6'd27, 6'd37, 6'd1, 12'd1000, lat, ok);
      got = exp_q.pop_front();
      tests_run++;
      if (!ok || lat != N + 1 || P !== got) begin
         fails++;
         $display("FAIL roundtrip_27_37_1: P=%0d lat=%0d expected P=%0d", P, lat, got);
      end
      last_p = got;
   endtask
`endif

   task automatic test_ignore_start;
      int acc_cyc;
      int i;
      logic [2*N-1:0] got;
      @(negedge clk);
      Multiplicand = 6'd9;
      Multiplier   = 6'd11;
      Addend       = 6'd5;
      Start        = 1'b1;
      exp_q.push_back(12'd104);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      Start   = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (Ready !== 1'b0 || P !== last_p) begin
         fails++;
         $display("FAIL busy_hold: Ready=%0b P=%0d expected Ready=0 P=%0d", Ready, P, last_p);
      end
      // Stray request with different operands while busy.
      Multiplicand = 6'd1;
      Multiplier   = 6'd1;
      Addend       = 6'd1;
      Start        = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      i = 0;
      while (!Ready && i < 50) begin
         @(negedge clk);
         i++;
      end
      got = exp_q.pop_front();
      tests_run++;
      if (Ready !== 1'b1 || cyc - acc_cyc != N + 1 || P !== got) begin
         fails++;
         $display("FAIL ignore_start: P=%0d lat=%0d expected P=%0d lat=%0d", P, cyc - acc_cyc, got, N + 1);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (Ready !== 1'b1 || P !== got) begin
         fails++;
         $display("FAIL no_queue: Ready=%0b P=%0d expected Ready=1 P=%0d", Ready, P, got);
      end
      last_p = got;
   endtask

   task automatic test_random;
      int lat;
      bit ok;
      logic [N-1:0] a, b, c;
      logic [2*N-1:0] got;
      for (int k = 0; k < 16; k++) begin
         a = N'($urandom_range(0, (1 << N) - 1));
         b = N'($urandom_range(0, (1 << N) - 1));
         c = N'($urandom_range(0, (1 << N) - 1));
         run_op(a, b, c, model(a, b, c), lat, ok);
         got = exp_q.pop_front();
         tests_run++;
         if (!ok || lat != N + 1 || P !== got) begin
            fails++;
            $display("FAIL random_%0d: a=%0d b=%0d c=%0d P=%0d lat=%0d expected P=%0d", k, a, b, c, P, lat, got);
         end
         last_p = got;
      end
   endtask

   task automatic test_back_to_back;
      logic [N-1:0] a[4], b[4], c[4];
      logic [2*N-1:0] got;
      int prev_cyc;
      int i;
      for (int k = 0; k < 4; k++) begin
         a[k] = N'($urandom_range(0, (1 << N) - 1));
         b[k] = N'($urandom_range(0, (1 << N) - 1));
         c[k] = N'($urandom_range(0, (1 << N) - 1));
      end
      @(negedge clk);
      Multiplicand = a[0];
      Multiplier   = b[0];
      Addend       = c[0];
      Start        = 1'b1;
      exp_q.push_back(model(a[0], b[0], c[0]));
      prev_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         i = 0;
         @(negedge clk);
         while (Ready && i < 20) begin
            @(negedge clk);
            i++;
         end
         if (k > 0) begin
            tests_run++;
            if (Ready !== 1'b0 || cyc - prev_cyc != N + 2) begin
               fails++;
               $display("FAIL issue_interval_%0d: interval=%0d expected %0d", k, cyc - prev_cyc, N + 2);
            end
         end
         prev_cyc = cyc;
         if (k < 3) begin
            Multiplicand = a[k+1];
            Multiplier   = b[k+1];
            Addend       = c[k+1];
            exp_q.push_back(model(a[k+1], b[k+1], c[k+1]));
         end else begin
            Start = 1'b0;
         end
         i = 0;
         while (!Ready && i < 50) begin
            @(negedge clk);
            i++;
         end
         got = exp_q.pop_front();
         tests_run++;
         if (Ready !== 1'b1 || P !== got) begin
            fails++;
            $display("FAIL back_to_back_%0d: P=%0d Ready=%0b expected P=%0d", k, P, Ready, got);
         end
         last_p = got;
      end
      Start = 1'b0;
   endtask

   task automatic test_async_reset;
      int lat;
      bit ok;
      logic [2*N-1:0] got;
      @(negedge clk);
      Multiplicand = 6'd13;
      Multiplier   = 6'd9;
      Addend       = 6'd2;
      Start        = 1'b1;
      exp_q.push_back(model(6'd13, 6'd9, 6'd2));
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      // The pending operation is abandoned.
      exp_q.delete();
      tests_run++;
      if (P !== '0) begin
         fails++;
         $display("FAIL async_reset_p: P=%0d expected 0", P);
      end
      tests_run++;
      if (Ready !== 1'b1) begin
         fails++;
         $display("FAIL async_reset_ready: Ready=%0b expected 1", Ready);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(6'd2, 6'd3, 6'd0, 12'd6, lat, ok);
      got = exp_q.pop_front();
      tests_run++;
      if (!ok || lat != N + 1 || P !== got) begin
         fails++;
         $display("FAIL after_reset_2_3_0: P=%0d lat=%0d expected P=%0d lat=%0d", P, lat, got, N + 1);
      end
      last_p = got;
   endtask

   // ---------------- main sequence + report ----------------
   initial begin
      tests_run    = 0;
      fails        = 0;
      cyc          = 0;
      last_p       = '0;
      rst          = 1'b1;
      Start        = 1'b0;
      Multiplicand = '0;
      Multiplier   = '0;
      Addend       = '0;
      test_reset();
      test_basic();
`ifdef MUL_SIGNED_EN
      test_signed();
`else
      test_max();
      test_roundtrip();
`endif
      test_ignore_start();
      test_random();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
